// File: rtl/pong_pixel_renderer.sv
// -----------------------------------------------------------------------------
// pong_pixel_renderer
//
// Pixel-generation stage that sits directly after the VGA timing generator.
// It runs a one-ball / one-paddle game and draws it. The game state advances
// once per frame, on the cycle where frame_tick is high. That cycle falls in
// vertical blank, so a visible frame never shows a mix of old and new
// positions. Colour and syncs leave through one register stage, which keeps
// them aligned at the DAC pins.
//
// Optional feature: define PONG_BORDER_EN to draw a 4-pixel grey (888) border
// around the visible area. The border is drawn below the ball and paddle and
// above the background. It only changes the picture; the collision limits do
// not change.
//
// Ports:
//   CLK, RESET          pixel clock; asynchronous active-high reset
//   hc, vc              horizontal / vertical counters (10 bit)
//   is_blanking         high outside the visible area
//   hsync_in, vsync_in  raw syncs, active low
//   btn_left/btn_right  paddle controls, already synchronised, level sensitive
//   red/green/blue      registered 4-bit colour channels
//   hsync/vsync         syncs delayed one cycle to line up with the colour
//   score               successful returns, saturating at 255
//   frame_tick          combinational, high when hc == 0 && vc == V_VISIBLE
// -----------------------------------------------------------------------------
module pong_pixel_renderer #(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 64,
    parameter int PADDLE_H    = 8,
    parameter int PADDLE_Y    = 464,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       is_blanking,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] score,
    output logic       frame_tick
);
    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

    localparam int MCW = $clog2(MISS_FRAMES);

    // All position arithmetic uses 11 bits. This leaves room for sums such
    // as ball_y + size + step without wrap-around.
    localparam logic [10:0] BALL_X_MAX   = 11'(H_VISIBLE - BALL_SIZE);
    localparam logic [10:0] BALL_Y_MAX   = 11'(V_VISIBLE - BALL_SIZE);
    localparam logic [10:0] BALL_X_CTR   = 11'((H_VISIBLE - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y_CTR   = 11'((V_VISIBLE - BALL_SIZE) / 2);
    localparam logic [10:0] PADDLE_X_MAX = 11'(H_VISIBLE - PADDLE_W);
    localparam logic [10:0] PADDLE_X_CTR = 11'((H_VISIBLE - PADDLE_W) / 2);
    localparam logic [10:0] BSIZE        = 11'(BALL_SIZE);
    localparam logic [10:0] BSTEP        = 11'(BALL_STEP);
    localparam logic [10:0] PSTEP        = 11'(PADDLE_STEP);
    localparam logic [10:0] PW           = 11'(PADDLE_W);
    localparam logic [10:0] PH           = 11'(PADDLE_H);
    localparam logic [10:0] PY           = 11'(PADDLE_Y);
    localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_FRAMES - 1);

    state_t          state_reg, state_next;
    logic [10:0]     ball_x_reg, ball_x_next;
    logic [10:0]     ball_y_reg, ball_y_next;
    logic [10:0]     paddle_x_reg, paddle_x_next;
    logic            dx_reg, dx_next;          // 1 = moving right
    logic            dy_reg, dy_next;          // 1 = moving down
    logic [MCW-1:0]  miss_cnt_reg, miss_cnt_next;
    logic [7:0]      score_reg, score_next;
    logic [11:0]     rgb_reg, rgb_next;
    logic            hsync_reg, vsync_reg;

    logic [10:0]     hc_w, vc_w;
    logic            ball_hit, paddle_hit, paddle_catch;

    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};

    assign frame_tick = (hc == 10'd0) && (vc == 10'(V_VISIBLE));

    // The ball is caught when, moving down, its next step would reach the
    // paddle's top row, it is not already below that row, and it overlaps
    // the paddle horizontally. All of these use pre-update values.
    assign paddle_catch = dy_reg
                       && (ball_y_reg + BSIZE + BSTEP >= PY)
                       && (ball_y_reg + BSIZE <= PY)
                       && (ball_x_reg + BSIZE > paddle_x_reg)
                       && (ball_x_reg < paddle_x_reg + PW);

    // ---------------------------------------------------------------- game
    always_comb begin
        state_next    = state_reg;
        ball_x_next   = ball_x_reg;
        ball_y_next   = ball_y_reg;
        paddle_x_next = paddle_x_reg;
        dx_next       = dx_reg;
        dy_next       = dy_reg;
        miss_cnt_next = miss_cnt_reg;
        score_next    = score_reg;

        // The paddle is frozen while the miss screen is shown.
        if (state_reg != MISS) begin
            if (btn_left && !btn_right) begin
                paddle_x_next = (paddle_x_reg < PSTEP) ? 11'd0 : paddle_x_reg - PSTEP;
            end else if (btn_right && !btn_left) begin
                paddle_x_next = (paddle_x_reg + PSTEP >= PADDLE_X_MAX) ? PADDLE_X_MAX
                                                                       : paddle_x_reg + PSTEP;
            end
        end

        unique case (state_reg)
            SERVE: begin
                ball_x_next = BALL_X_CTR;
                ball_y_next = BALL_Y_CTR;
                dx_next     = 1'b1;
                dy_next     = 1'b1;
                if (btn_left || btn_right) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (dx_reg) begin
                    if (ball_x_reg + BSTEP >= BALL_X_MAX) begin
                        ball_x_next = BALL_X_MAX;
                        dx_next     = 1'b0;
                    end else begin
                        ball_x_next = ball_x_reg + BSTEP;
                    end
                end else begin
                    if (ball_x_reg <= BSTEP) begin
                        ball_x_next = 11'd0;
                        dx_next     = 1'b1;
                    end else begin
                        ball_x_next = ball_x_reg - BSTEP;
                    end
                end

                if (!dy_reg && (ball_y_reg <= BSTEP)) begin
                    ball_y_next = 11'd0;
                    dy_next     = 1'b1;
                end else if (paddle_catch) begin
                    ball_y_next = PY - BSIZE;
                    dy_next     = 1'b0;
                    score_next  = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
                end else if (dy_reg && (ball_y_reg + BSTEP >= BALL_Y_MAX)) begin
                    // The ball freezes where it was missed; this also cancels
                    // the X step computed above.
                    state_next    = MISS;
                    ball_x_next   = ball_x_reg;
                    ball_y_next   = ball_y_reg;
                    dx_next       = dx_reg;
                    miss_cnt_next = '0;
                end else begin
                    ball_y_next = dy_reg ? ball_y_reg + BSTEP : ball_y_reg - BSTEP;
                end
            end
            MISS: begin
                // The counter enters at 0. When it is already at MISS_LAST,
                // the game leaves on this tick, so exactly MISS_FRAMES ticks
                // are spent here.
                if (miss_cnt_reg == MISS_LAST) begin
                    state_next  = SERVE;
                    ball_x_next = BALL_X_CTR;
                    ball_y_next = BALL_Y_CTR;
                    dx_next     = 1'b1;
                    dy_next     = 1'b1;
                end else begin
                    miss_cnt_next = miss_cnt_reg + 1'b1;
                end
            end
            default: state_next = SERVE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= SERVE;
            ball_x_reg   <= BALL_X_CTR;
            ball_y_reg   <= BALL_Y_CTR;
            paddle_x_reg <= PADDLE_X_CTR;
            dx_reg       <= 1'b1;
            dy_reg       <= 1'b1;
            miss_cnt_reg <= '0;
            score_reg    <= 8'd0;
        end else if (frame_tick) begin
            state_reg    <= state_next;
            ball_x_reg   <= ball_x_next;
            ball_y_reg   <= ball_y_next;
            paddle_x_reg <= paddle_x_next;
            dx_reg       <= dx_next;
            dy_reg       <= dy_next;
            miss_cnt_reg <= miss_cnt_next;
            score_reg    <= score_next;
        end
    end

    // --------------------------------------------------------------- pixels
    assign ball_hit   = (hc_w >= ball_x_reg) && (hc_w < ball_x_reg + BSIZE)
                     && (vc_w >= ball_y_reg) && (vc_w < ball_y_reg + BSIZE);
    assign paddle_hit = (hc_w >= paddle_x_reg) && (hc_w < paddle_x_reg + PW)
                     && (vc_w >= PY) && (vc_w < PY + PH);

`ifdef PONG_BORDER_EN
    logic border_hit;
    assign border_hit = (hc_w < 11'd4) || (hc_w >= 11'(H_VISIBLE - 4))
                     || (vc_w < 11'd4) || (vc_w >= 11'(V_VISIBLE - 4));
`endif

    always_comb begin
        if (is_blanking) begin
            rgb_next = 12'h000;
        end else if (ball_hit) begin
            rgb_next = 12'hFFF;
        end else if (paddle_hit) begin
            rgb_next = 12'h0F0;
`ifdef PONG_BORDER_EN
        end else if (border_hit) begin
            rgb_next = 12'h888;
`endif
        end else if (state_reg == MISS) begin
            rgb_next = 12'h800;
        end else begin
            rgb_next = 12'h001;
        end
    end

    // Colour and syncs go through the same register stage, so they stay
    // aligned.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rgb_reg   <= 12'h000;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            rgb_reg   <= rgb_next;
            hsync_reg <= hsync_in;
            vsync_reg <= vsync_in;
        end
    end

    assign red   = rgb_reg[11:8];
    assign green = rgb_reg[7:4];
    assign blue  = rgb_reg[3:0];
    assign hsync = hsync_reg;
    assign vsync = vsync_reg;
    assign score = score_reg;

endmodule
